// File: rtl/cam_capture_ctrl_pkg.sv
// rtl/cam_capture_ctrl_pkg.sv - shared camera capture types and frame constants
package cam_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC_HI = 3'd1,
    ST_SYNC_LO = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } cam_state_e;

  localparam int PIXEL_WIDTH    = 16;
  localparam int DEF_IMG_WIDTH  = 40;
  localparam int DEF_IMG_HEIGHT = 30;
  localparam int FRAME_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

endpackage

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - frame-aligned camera capture into the image scratchpad
module cam_capture_ctrl
  import cam_capture_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cam_vsync,
  input  logic                   cam_href,
  input  logic [7:0]             cam_dat,
  output logic                   cam_dat_en,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err
);

  // Counters are sized to hold the saturation value itself.
  localparam int PCW = $clog2(IMG_WIDTH + 1);
  localparam int LCW = $clog2(IMG_HEIGHT + 1);
  localparam logic [PCW-1:0]        PIX_MAX   = PCW'(IMG_WIDTH);
  localparam logic [LCW-1:0]        LINE_MAX  = LCW'(IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_WIDTH);

  cam_state_e             state_q, state_d;
  logic                   phase_q, phase_d;
  logic [7:0]             hi_byte_q, hi_byte_d;
  logic [PCW-1:0]         pixel_cnt_q, pixel_cnt_d;
  logic [LCW-1:0]         line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;
  logic                   href_q, href_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   frame_err_q, frame_err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      hi_byte_q   <= 8'h00;
      pixel_cnt_q <= '0;
      line_cnt_q  <= '0;
      line_base_q <= '0;
      href_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_byte_q   <= hi_byte_d;
      pixel_cnt_q <= pixel_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_base_q <= line_base_d;
      href_q      <= href_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sequencer: frame alignment, byte pairing, write clipping and line/frame accounting.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_byte_d   = hi_byte_q;
    pixel_cnt_d = pixel_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_base_d = line_base_q;
    href_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = frame_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SYNC_HI;
          frame_err_d = 1'b0;
          phase_d     = 1'b0;
          pixel_cnt_d = '0;
          line_cnt_d  = '0;
          line_base_d = '0;
        end
      end

      ST_SYNC_HI: begin
        if (cam_vsync) begin
          state_d = ST_SYNC_LO;
        end
      end

      ST_SYNC_LO: begin
        if (!cam_vsync) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // The edge detector only tracks href while capturing so a stale
        // high level from blanking can never fake a line end.
        href_d = cam_href;
        if (cam_href) begin
          if (!phase_q) begin
            hi_byte_d = cam_dat;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pixel_cnt_q < PIX_MAX) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = line_base_q + ADDR_WIDTH'(pixel_cnt_q);
              wr_data_d   = {hi_byte_q, cam_dat};
              pixel_cnt_d = pixel_cnt_q + PCW'(1);
            end
          end
        end else if (href_q) begin
          if (pixel_cnt_q < PIX_MAX) begin
            frame_err_d = 1'b1;
          end
          line_base_d = line_base_q + LINE_STEP;
          line_cnt_d  = line_cnt_q + LCW'(1);
          pixel_cnt_d = '0;
          phase_d     = 1'b0;
          if (line_cnt_d == LINE_MAX) begin
            state_d = ST_FINISH;
          end
        end
        // A line end completing the frame on this edge takes precedence
        // over a simultaneous vsync rise.
        if (cam_vsync && (state_d != ST_FINISH)) begin
          frame_err_d = 1'b1;
          state_d     = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_q == ST_SYNC_HI) || (state_q == ST_SYNC_LO) || (state_q == ST_CAPTURE);
  assign cam_dat_en = (state_q == ST_SYNC_LO) || (state_q == ST_CAPTURE);
  assign done       = (state_q == ST_FINISH);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_err  = frame_err_q;

endmodule
